// File: rtl/enable_counter.sv
// Free-running up-counter with count enable and a one-cycle terminal-count pulse.
// Define COUNTER_SATURATE_EN to make the count stop at its maximum instead of wrapping.
module enable_counter #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    output logic [COUNTER_WIDTH-1:0] o_counter,
    output logic                     o_wrap
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
`ifdef COUNTER_SATURATE_EN
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;
`endif

    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic                     wrap_q, wrap_d;

    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        if (i_enable) begin
`ifdef COUNTER_SATURATE_EN
            // Pulse only on the edge that first lands on max; parked at max stays quiet.
            if (counter_q != CNT_MAX) begin
                counter_d = counter_q + 1'b1;
                wrap_d    = (counter_q == CNT_MAX_M1);
            end
`else
            counter_d = counter_q + 1'b1;
            wrap_d    = (counter_q == CNT_MAX);
`endif
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            counter_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_counter = counter_q;
    assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_enable_counter.sv
// Self-checking bench for enable_counter: a 16-bit and a 4-bit instance share stimulus
// and are compared against constant tables, hand sequences and an arithmetic reference model.
module tb_enable_counter;

    logic        clk;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] cnt16;
    logic        wrap16;
    logic [3:0]  cnt4;
    logic        wrap4;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned m16, m4;
    bit              mw16, mw4;

    enable_counter #(.COUNTER_WIDTH(16)) dut16 (
        .i_clock  (clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .o_counter(cnt16),
        .o_wrap   (wrap16)
    );

    enable_counter #(.COUNTER_WIDTH(4)) dut4 (
        .i_clock  (clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .o_counter(cnt4),
        .o_wrap   (wrap4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit en;
        int exp_cnt;
        bit exp_wrap;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: counts are plain integers, wrap is modulo 2^W or clamp at 2^W-1.
    function automatic void model_one(input int w, input bit rst, input bit en,
                                      inout longint unsigned m, inout bit mw);
        longint unsigned max_v;
        max_v = (64'd1 << w) - 1;
        if (!rst) begin
            m  = 0;
            mw = 0;
        end else if (!en) begin
            mw = 0;
        end else begin
`ifdef COUNTER_SATURATE_EN
            mw = (m + 1 == max_v);
            if (m < max_v) m = m + 1;
`else
            mw = (m == max_v);
            m  = (m + 1) % (max_v + 1);
`endif
        end
    endfunction

    task automatic step(input bit rst, input bit en);
        @(negedge clk);
        i_reset  = rst;
        i_enable = en;
        @(posedge clk);
        model_one(16, rst, en, m16, mw16);
        model_one(4,  rst, en, m4,  mw4);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_cnt16"},  64'(cnt16),  m16);
        check({tag, "_wrap16"}, 64'(wrap16), 64'(mw16));
        check({tag, "_cnt4"},   64'(cnt4),   m4);
        check({tag, "_wrap4"},  64'(wrap4),  64'(mw4));
    endtask

    vec_t tbl[12];
    bit   wrap16_seen;

    initial begin
        tbl[0]  = '{0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0};
        tbl[2]  = '{1, 1, 1, 0};
        tbl[3]  = '{1, 1, 2, 0};
        tbl[4]  = '{1, 0, 2, 0};
        tbl[5]  = '{1, 1, 3, 0};
        tbl[6]  = '{1, 0, 3, 0};
        tbl[7]  = '{1, 0, 3, 0};
        tbl[8]  = '{1, 1, 4, 0};
        tbl[9]  = '{0, 1, 0, 0};
        tbl[10] = '{1, 1, 1, 0};
        tbl[11] = '{1, 1, 2, 0};

        i_reset  = 1'b0;
        i_enable = 1'b0;
        m16 = 0; m4 = 0; mw16 = 0; mw4 = 0;

        // Reset state
        #2;
        check("reset_cnt16",  64'(cnt16),  64'd0);
        check("reset_wrap16", 64'(wrap16), 64'd0);
        step(0, 1);
        check("reset_hold_cnt16", 64'(cnt16), 64'd0);
        check("reset_hold_cnt4",  64'(cnt4),  64'd0);

        // Table of short sequences, counts small enough to be build-independent
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].en);
            check($sformatf("tbl%0d_cnt16", i),  64'(cnt16),  64'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_wrap16", i), 64'(wrap16), 64'(tbl[i].exp_wrap));
            check($sformatf("tbl%0d_cnt4", i),   64'(cnt4),   64'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_wrap4", i),  64'(wrap4),  64'(tbl[i].exp_wrap));
        end

        // Enable count to 75
        step(0, 0);
        wrap16_seen = 0;
        for (int i = 0; i < 75; i++) begin
            step(1, 1);
            check_model("cnt75");
            if (wrap16) wrap16_seen = 1;
        end
        check("cnt75_value",   64'(cnt16), 64'h004B);
        check("cnt75_no_wrap", 64'(wrap16_seen), 64'd0);

        // Hold one edge then 15 more
        step(1, 0);
        check("hold_cnt16", 64'(cnt16), 64'd75);
        for (int i = 0; i < 15; i++) step(1, 1);
        check("hold_then_90", 64'(cnt16), 64'd90);

        // Reset mid-count near 100
        for (int i = 0; i < 10; i++) step(1, 1);
        check("near100", 64'(cnt16), 64'd100);
        for (int i = 0; i < 15; i++) begin
            step(0, 1);
            check_model("midrst");
        end
        check("midrst_zero", 64'(cnt16), 64'd0);
        for (int i = 0; i < 50; i++) step(1, 1);
        check("post_release_50", 64'(cnt16), 64'd50);

        // 4-bit wrap / saturate sequence from 0
        step(0, 0);
`ifdef COUNTER_SATURATE_EN
        for (int i = 1; i <= 20; i++) begin
            step(1, 1);
            check($sformatf("sat4_cnt_e%0d", i),  64'(cnt4),  64'((i < 15) ? i : 15));
            check($sformatf("sat4_wrap_e%0d", i), 64'(wrap4), 64'(i == 15));
        end
`else
        for (int i = 1; i <= 16; i++) begin
            step(1, 1);
            check($sformatf("wrap4_cnt_e%0d", i),  64'(cnt4),  64'(i % 16));
            check($sformatf("wrap4_wrap_e%0d", i), 64'(wrap4), 64'(i == 16));
        end
        step(1, 1);
        check("wrap4_after_cnt",  64'(cnt4),  64'd1);
        check("wrap4_after_wrap", 64'(wrap4), 64'd0);
`endif

        // Async reset mid-cycle from 0x0123
        step(0, 0);
        for (int i = 0; i < 291; i++) step(1, 1);
        check("pre_async_cnt16", 64'(cnt16), 64'h0123);
        #2;
        i_reset = 1'b0;
        m16 = 0; m4 = 0; mw16 = 0; mw4 = 0;
        #1;
        check("async_cnt16",  64'(cnt16),  64'd0);
        check("async_wrap16", 64'(wrap16), 64'd0);
        check("async_cnt4",   64'(cnt4),   64'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            check_model("async_hold");
        end

        // Randomised run against the reference model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0));
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
